order_frame_tx: RTL and testbench
=================================

# order_frame_tx

Frame transmitter for the order-book serial link. It accepts one parallel order record (address, buy/sell price, buy/sell volume) from the mux side and serializes it into the 19-byte delimited frame. It drives the byte-level `uart_tx` core one byte at a time using that core's DV/done handshake. It is the transmit-side counterpart of the frame receiver and shares its frame format.

## Interface
Parameters:
- `START_BYTE`, default 8'hF0: frame start delimiter.
- `STOP_BYTE`, default 8'h0F: frame stop delimiter.
- `GAP_CYCLES`, default 0: idle clocks inserted after each byte's `uart_tx_done` before the next byte is issued. Range 0–255.

Ports:
- `clk`  in  1: the single clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `tx_addr`  in  8: record address.
- `tx_buyprice`  in  32: buy price.
- `tx_sellprice`  in  32: sell price.
- `tx_buyvol`  in  32: buy volume.
- `tx_sellvol`  in  32: sell volume.
- `tx_dv`  in  1: record valid, single-cycle qualifier.
- `tx_ready`  out  1: block is idle and will accept `tx_dv`.
- `tx_drop`  out  1: one-cycle pulse when `tx_dv` arrives while `tx_ready` is low.
- `frame_done`  out  1: one-cycle pulse after the last byte completes.
- `uart_tx_dv`  out  1: one-cycle byte strobe to `uart_tx`.
- `uart_tx_data`  out  8: byte to `uart_tx`. Valid whenever `uart_tx_dv` is high.
- `uart_tx_busy`  in  1: `uart_tx` `o_Tx_Active`.
- `uart_tx_done`  in  1: `uart_tx` `o_Tx_Done`, one-cycle pulse.

## Operation
- Byte order:
  - index 0: START
  - index 1: ADDR
  - indices 2–5: BUYPRICE[31:24], [23:16], [15:8], [7:0]
  - indices 6–9: SELLPRICE, MSB first
  - indices 10–13: BUYVOL, MSB first
  - indices 14–17: SELLVOL, MSB first
  - index 18: STOP
- On `tx_dv && tx_ready`, all five fields are captured into a shadow register. Inputs may change afterwards without affecting the frame.
- FSM states:
  - IDLE: `tx_ready`=1. On accept, clear the byte index and go to ISSUE.
  - ISSUE: if `uart_tx_busy`=0, pulse `uart_tx_dv` with byte[index] and go to WAIT. Otherwise stay in ISSUE.
  - WAIT: on `uart_tx_done`, go to GAP if `GAP_CYCLES`>0. Otherwise go to ISSUE if the index is not last, or to DONE if it is last. The index increments when leaving WAIT.
  - GAP: count `GAP_CYCLES` clocks, then go to ISSUE, or to DONE if the last byte was sent.
  - DONE: pulse `frame_done`, return to IDLE.
- The byte index is 5 bits and never wraps past the last index.
- `tx_dv` while not ready: the record is discarded, `tx_drop` pulses, and the frame in flight is unaffected.
- `uart_tx_done` outside WAIT is ignored.
- Reset, including mid-frame: FSM returns to IDLE and the shadow register, index and gap counter clear. The partial frame is abandoned; the receiver resynchronizes on the next START.

## Timing
- Reset values:
  - `tx_ready`=1
  - `tx_drop`=0
  - `frame_done`=0
  - `uart_tx_dv`=0
  - `uart_tx_data`=8'h00
- `tx_dv` accepted in cycle N: `tx_ready` is low from N+1, and the START byte's `uart_tx_dv` fires at N+1 if `uart_tx_busy` is low.
- `uart_tx_done` in cycle M: the next `uart_tx_dv` fires at M+1+`GAP_CYCLES` (busy permitting).
- STOP byte's done in cycle M: `frame_done` is high at M+1+`GAP_CYCLES`, and `tx_ready` is high at M+2+`GAP_CYCLES`. A `tx_dv` in that cycle is accepted (back-to-back frames).
- `uart_tx_dv` is never high for two consecutive cycles.

## Configuration
- `ORDER_FRAME_TX_CHECKSUM_EN` defined: a checksum byte equal to the XOR of frame bytes 1–17 is inserted at index 18 and STOP moves to index 19 (20-byte frame). The receiver must be built with the matching option.
- Undefined: standard 19-byte frame and no checksum logic.

## Structure
- Shared package `order_frame_pkg`:
  - START/STOP constants
  - frame length constants (19, and 20 with checksum)
  - byte-index localparams
  - FSM state enum
  - the order-record struct (addr plus four 32-bit fields), also used by the receiver
- One sub-module, `order_frame_byte_mux`: combinational selection of byte[index] from the shadow record, including the checksum when enabled.

## Test plan
- Single frame, GAP=0, with a behavioural `uart_tx` model: addr=8'h05, buyprice=32'h01020304, sellprice=32'h11121314, buyvol=32'h21222324, sellvol=32'h31323334. Required bytes in order: F0,05,01,02,03,04,11,12,13,14,21,22,23,24,31,32,33,34,0F. Exactly one `frame_done` and 19 `uart_tx_dv` pulses.
- GAP_CYCLES=3: each `uart_tx_dv` occurs exactly 4 clocks after the preceding `uart_tx_done`.
- `tx_dv` pulsed again at byte 7 with different data: `tx_drop` pulses once and the frame bytes are unchanged.
- `uart_tx_busy` held high for 10 cycles at reset exit, then `tx_dv`: `uart_tx_dv` waits for busy low, then sends F0.
- `reset_n` low for 1 cycle after byte 9's done: outputs return to reset values. A following frame with addr=8'hAA is transmitted complete from F0.
- With `ORDER_FRAME_TX_CHECKSUM_EN` and the first test's record: byte 18 equals 8'h05 XOR all 16 field bytes, followed by 0F, 20 bytes total.

Source files
------------

// File: rtl/order_frame_pkg.sv
// rtl/order_frame_pkg.sv - shared order-frame format; frame grows to 20 bytes with ORDER_FRAME_TX_CHECKSUM_EN
package order_frame_pkg;

    localparam logic [7:0] START_BYTE_DEFAULT = 8'hF0;
    localparam logic [7:0] STOP_BYTE_DEFAULT  = 8'h0F;

    localparam int FRAME_LEN_STD  = 19;
    localparam int FRAME_LEN_CSUM = 20;
`ifdef ORDER_FRAME_TX_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_STD;
`endif

    localparam int NUM_DATA_BYTES = 17;
    localparam int REC_W          = 8 * NUM_DATA_BYTES;

    localparam logic [4:0] IDX_START     = 5'd0;
    localparam logic [4:0] IDX_ADDR      = 5'd1;
    localparam logic [4:0] IDX_BUYPRICE  = 5'd2;
    localparam logic [4:0] IDX_SELLPRICE = 5'd6;
    localparam logic [4:0] IDX_BUYVOL    = 5'd10;
    localparam logic [4:0] IDX_SELLVOL   = 5'd14;
    localparam logic [4:0] IDX_CSUM      = 5'd18;
    localparam logic [4:0] IDX_STOP      = 5'(FRAME_LEN - 1);
    localparam logic [4:0] IDX_LAST      = IDX_STOP;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } tx_state_t;

    // Field order matches wire order, so byte k (1..17) sits at bits [(17-k)*8 +: 8].
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] buyprice;
        logic [31:0] sellprice;
        logic [31:0] buyvol;
        logic [31:0] sellvol;
    } order_rec_t;

endpackage

// File: rtl/order_frame_tx_if.sv
// rtl/order_frame_tx_if.sv - record-side and uart_tx-side signals of the frame transmitter
interface order_frame_tx_if;
    logic [7:0]  tx_addr;
    logic [31:0] tx_buyprice;
    logic [31:0] tx_sellprice;
    logic [31:0] tx_buyvol;
    logic [31:0] tx_sellvol;
    logic        tx_dv;
    logic        tx_ready;
    logic        tx_drop;
    logic        frame_done;
    logic        uart_tx_dv;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        uart_tx_done;

    modport master (
        input  tx_addr, tx_buyprice, tx_sellprice, tx_buyvol, tx_sellvol, tx_dv,
        input  uart_tx_busy, uart_tx_done,
        output tx_ready, tx_drop, frame_done, uart_tx_dv, uart_tx_data
    );

    modport slave (
        output tx_addr, tx_buyprice, tx_sellprice, tx_buyvol, tx_sellvol, tx_dv,
        output uart_tx_busy, uart_tx_done,
        input  tx_ready, tx_drop, frame_done, uart_tx_dv, uart_tx_data
    );
endinterface

// File: rtl/order_frame_byte_mux.sv
// rtl/order_frame_byte_mux.sv - byte[idx] select from the shadow record; checksum byte under ORDER_FRAME_TX_CHECKSUM_EN
module order_frame_byte_mux
    import order_frame_pkg::*;
#(
    parameter logic [7:0] START_BYTE = START_BYTE_DEFAULT,
    parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEFAULT
) (
    input  order_rec_t rec,
    input  logic [4:0] idx,
    output logic [7:0] data
);

    logic [REC_W-1:0] flat;
    assign flat = rec;

`ifdef ORDER_FRAME_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = 8'h00;
        for (int k = 0; k < NUM_DATA_BYTES; k++) begin
            csum = csum ^ flat[k*8 +: 8];
        end
    end
`endif

    always_comb begin
        data = 8'h00;
        if (idx == IDX_START) begin
            data = START_BYTE;
        end
        for (int k = 1; k <= NUM_DATA_BYTES; k++) begin
            if (idx == 5'(k)) begin
                data = flat[(NUM_DATA_BYTES - k)*8 +: 8];
            end
        end
`ifdef ORDER_FRAME_TX_CHECKSUM_EN
        if (idx == IDX_CSUM) begin
            data = csum;
        end
`endif
        if (idx == IDX_STOP) begin
            data = STOP_BYTE;
        end
    end

endmodule

// File: rtl/order_frame_tx.sv
// rtl/order_frame_tx.sv - serializes one order record into a delimited frame over the uart_tx DV/done handshake
module order_frame_tx
    import order_frame_pkg::*;
#(
    parameter logic [7:0] START_BYTE = START_BYTE_DEFAULT,
    parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEFAULT,
    parameter int          GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    order_frame_tx_if.master  bus
);

    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    tx_state_t  state_q, state_d;
    logic [4:0] idx_q;
    logic [7:0] gap_q;
    logic       last_sent_q;
    order_rec_t rec_q;
    logic [7:0] cur_byte;

    logic accept, issue, wait_done, is_last;

    assign accept    = bus.tx_dv && (state_q == ST_IDLE);
    assign issue     = (state_q == ST_ISSUE) && !bus.uart_tx_busy;
    assign wait_done = (state_q == ST_WAIT) && bus.uart_tx_done;
    assign is_last   = (idx_q == IDX_LAST);

    order_frame_byte_mux #(
        .START_BYTE (START_BYTE),
        .STOP_BYTE  (STOP_BYTE)
    ) u_byte_mux (
        .rec  (rec_q),
        .idx  (idx_q),
        .data (cur_byte)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (!bus.uart_tx_busy) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.uart_tx_done) begin
                    if (GAP_CYCLES != 0) state_d = ST_GAP;
                    else if (is_last)    state_d = ST_DONE;
                    else                 state_d = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = last_sent_q ? ST_DONE : ST_ISSUE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // last_sent_q remembers STOP went out, since the index saturates instead of passing the last slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            gap_q       <= 8'd0;
            last_sent_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rec_q <= '{addr:      bus.tx_addr,
                           buyprice:  bus.tx_buyprice,
                           sellprice: bus.tx_sellprice,
                           buyvol:    bus.tx_buyvol,
                           sellvol:   bus.tx_sellvol};
                idx_q       <= 5'd0;
                last_sent_q <= 1'b0;
            end
            if (wait_done) begin
                if (is_last) last_sent_q <= 1'b1;
                else         idx_q       <= idx_q + 5'd1;
            end
            if (state_q == ST_GAP && gap_q != GAP_LAST) gap_q <= gap_q + 8'd1;
            else                                        gap_q <= 8'd0;
        end
    end

    assign bus.tx_ready     = (state_q == ST_IDLE);
    assign bus.tx_drop      = bus.tx_dv && (state_q != ST_IDLE);
    assign bus.frame_done   = (state_q == ST_DONE);
    assign bus.uart_tx_dv   = issue;
    assign bus.uart_tx_data = issue ? cur_byte : 8'h00;

endmodule

// File: tb/tb_order_frame_tx.sv
// tb/tb_order_frame_tx.sv - scoreboard bench for order_frame_tx (GAP 0 and GAP 3 instances)
module tb_order_frame_tx;
    import order_frame_pkg::*;

`ifdef ORDER_FRAME_TX_CHECKSUM_EN
    localparam int NB = 20;
`else
    localparam int NB = 19;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic m_rst;
    logic force_busy;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    order_frame_tx_if ifc0();
    order_frame_tx_if ifc3();

    order_frame_tx #(.GAP_CYCLES(0)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc0.master)
    );

    order_frame_tx #(.GAP_CYCLES(3)) u_dut_gap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc3.master)
    );

    // Behavioural uart_tx: busy from the edge after DV, done pulse 3 clocks later.
    logic       m0_busy, m3_busy, m0_done, m3_done;
    logic [2:0] m0_cnt, m3_cnt;

    always @(posedge clk) begin
        if (m_rst) begin
            m0_busy <= 1'b0; m0_done <= 1'b0; m0_cnt <= 3'd0;
        end else begin
            m0_done <= 1'b0;
            if (!m0_busy && ifc0.uart_tx_dv) begin
                m0_busy <= 1'b1; m0_cnt <= 3'd3;
            end else if (m0_busy) begin
                if (m0_cnt == 3'd1) begin m0_busy <= 1'b0; m0_done <= 1'b1; end
                else m0_cnt <= m0_cnt - 3'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (m_rst) begin
            m3_busy <= 1'b0; m3_done <= 1'b0; m3_cnt <= 3'd0;
        end else begin
            m3_done <= 1'b0;
            if (!m3_busy && ifc3.uart_tx_dv) begin
                m3_busy <= 1'b1; m3_cnt <= 3'd3;
            end else if (m3_busy) begin
                if (m3_cnt == 3'd1) begin m3_busy <= 1'b0; m3_done <= 1'b1; end
                else m3_cnt <= m3_cnt - 3'd1;
            end
        end
    end

    assign ifc0.uart_tx_busy = m0_busy | force_busy;
    assign ifc0.uart_tx_done = m0_done;
    assign ifc3.uart_tx_busy = m3_busy;
    assign ifc3.uart_tx_done = m3_done;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp1[$];

    task automatic push_frame(input order_rec_t r);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(r.addr);
        for (int i = 3; i >= 0; i--) b.push_back(r.buyprice[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(r.sellprice[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(r.buyvol[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(r.sellvol[i*8 +: 8]);
        x = 8'h00;
        exp_q.push_back(8'hF0);
        foreach (b[i]) begin exp_q.push_back(b[i]); x = x ^ b[i]; end
`ifdef ORDER_FRAME_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_q.push_back(8'h0F);
    endtask

    // Monitor for the GAP=0 instance: scoreboard pop on each byte strobe.
    int   dv_total = 0, done_total = 0, drop_total = 0, udone_total = 0;
    logic prev_dv  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (ifc0.uart_tx_dv === 1'b1) begin
            dv_total++;
            check("dv_back_to_back", {31'd0, prev_dv}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_byte", {24'd0, ifc0.uart_tx_data}, 32'hFFFF_FFFF);
            else                   check("frame_byte", {24'd0, ifc0.uart_tx_data}, {24'd0, exp_q.pop_front()});
        end
        prev_dv = (ifc0.uart_tx_dv === 1'b1);
        if (ifc0.frame_done === 1'b1) done_total++;
        if (ifc0.tx_drop === 1'b1)    drop_total++;
        if (m0_done === 1'b1)         udone_total++;
    end

    // Monitor for the GAP=3 instance: byte values plus done-to-DV spacing.
    int g_cnt = 0, g_frames = 0, last_done_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (ifc3.uart_tx_dv === 1'b1) begin
            if (g_cnt < exp1.size()) check("gap_byte", {24'd0, ifc3.uart_tx_data}, {24'd0, exp1[g_cnt]});
            else                     check("gap_extra_byte", 32'd1, 32'd0);
            if (g_cnt > 0) check("gap_spacing", cyc - last_done_cyc, 32'd4);
            g_cnt++;
        end
        if (m3_done === 1'b1)         last_done_cyc = cyc;
        if (ifc3.frame_done === 1'b1) g_frames++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input order_rec_t r, input logic dv);
        ifc0.tx_addr      = r.addr;
        ifc0.tx_buyprice  = r.buyprice;
        ifc0.tx_sellprice = r.sellprice;
        ifc0.tx_buyvol    = r.buyvol;
        ifc0.tx_sellvol   = r.sellvol;
        ifc0.tx_dv        = dv;
    endtask

    task automatic wait_frame_done(input string name);
        int n = 0;
        while (ifc0.frame_done !== 1'b1 && n < 600) begin step(); n++; end
        if (n >= 600) check(name, 32'd0, 32'd1);
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_ready"},   {31'd0, ifc0.tx_ready},   32'd1);
        check({tag, "_tx_drop"},    {31'd0, ifc0.tx_drop},    32'd0);
        check({tag, "_frame_done"}, {31'd0, ifc0.frame_done}, 32'd0);
        check({tag, "_uart_dv"},    {31'd0, ifc0.uart_tx_dv}, 32'd0);
        check({tag, "_uart_data"},  {24'd0, ifc0.uart_tx_data}, 32'd0);
    endtask

    order_rec_t rec1, rec_b, rec_junk, rec_d, rec_e, rec_aa;
    int base_dv, base_done, base_drop, base_ud, n;

    initial begin
        rec1     = '{addr: 8'h05, buyprice: 32'h01020304, sellprice: 32'h11121314,
                     buyvol: 32'h21222324, sellvol: 32'h31323334};
        rec_b    = '{addr: 8'h3C, buyprice: 32'hDEADBEEF, sellprice: 32'hCAFEF00D,
                     buyvol: 32'h00000001, sellvol: 32'h80000000};
        rec_junk = '{addr: 8'h77, buyprice: 32'h99999999, sellprice: 32'h88888888,
                     buyvol: 32'h77777777, sellvol: 32'h66666666};
        rec_d    = '{addr: 8'h5A, buyprice: 32'h00FF00FF, sellprice: 32'hFF00FF00,
                     buyvol: 32'h12345678, sellvol: 32'h9ABCDEF0};
        rec_e    = '{addr: 8'h42, buyprice: 32'h0A0B0C0D, sellprice: 32'h1A1B1C1D,
                     buyvol: 32'h2A2B2C2D, sellvol: 32'h3A3B3C3D};
        rec_aa   = '{addr: 8'hAA, buyprice: 32'h00000000, sellprice: 32'hFFFFFFFF,
                     buyvol: 32'h55555555, sellvol: 32'h0000AAAA};

        exp1 = '{8'hF0, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
                 8'h21, 8'h22, 8'h23, 8'h24, 8'h31, 8'h32, 8'h33, 8'h34};
`ifdef ORDER_FRAME_TX_CHECKSUM_EN
        exp1.push_back(8'h05);
`endif
        exp1.push_back(8'h0F);

        m_rst = 1'b1; reset_n = 1'b0; force_busy = 1'b0;
        drive0('0, 1'b0);
        ifc3.tx_addr = '0; ifc3.tx_buyprice = '0; ifc3.tx_sellprice = '0;
        ifc3.tx_buyvol = '0; ifc3.tx_sellvol = '0; ifc3.tx_dv = 1'b0;
        repeat (3) step();
        m_rst = 1'b0; reset_n = 1'b1;
        check_reset_values("rst");

        // Single frame on both instances; inputs scrambled right after accept.
        foreach (exp1[i]) exp_q.push_back(exp1[i]);
        base_dv = dv_total; base_done = done_total;
        drive0(rec1, 1'b1);
        ifc3.tx_addr = rec1.addr; ifc3.tx_buyprice = rec1.buyprice; ifc3.tx_sellprice = rec1.sellprice;
        ifc3.tx_buyvol = rec1.buyvol; ifc3.tx_sellvol = rec1.sellvol; ifc3.tx_dv = 1'b1;
        step();
        drive0(rec_junk, 1'b0);
        ifc3.tx_dv = 1'b0; ifc3.tx_addr = 8'hEE;
        check("ready_low_after_accept", {31'd0, ifc0.tx_ready}, 32'd0);
        check("start_dv_next_cycle", {31'd0, ifc0.uart_tx_dv}, 32'd1);
        wait_frame_done("frame1_timeout");
        check("ready_after_done", {31'd0, ifc0.tx_ready}, 32'd1);
        check("frame1_dv_count", dv_total - base_dv, NB);
        check("frame1_done_count", done_total - base_done, 32'd1);
        check("frame1_queue_empty", exp_q.size(), 32'd0);

        // Back-to-back accept, then a second record arrives mid-frame at byte 7.
        push_frame(rec_b);
        base_dv = dv_total; base_done = done_total; base_drop = drop_total;
        drive0(rec_b, 1'b1);
        step();
        drive0(rec_b, 1'b0);
        n = 0;
        while ((dv_total - base_dv) < 8 && n < 300) begin step(); n++; end
        if (n >= 300) check("byte7_timeout", 32'd0, 32'd1);
        drive0(rec_junk, 1'b1);
        step();
        drive0(rec_junk, 1'b0);
        wait_frame_done("frame2_timeout");
        check("drop_count", drop_total - base_drop, 32'd1);
        check("frame2_dv_count", dv_total - base_dv, NB);
        check("frame2_done_count", done_total - base_done, 32'd1);
        check("frame2_queue_empty", exp_q.size(), 32'd0);

        n = 0;
        while (g_frames < 1 && n < 600) begin step(); n++; end
        check("gap_frame_count", g_frames, 32'd1);
        check("gap_dv_count", g_cnt, NB);

        // Busy held high through reset exit; frame must wait for it.
        force_busy = 1'b1; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        base_dv = dv_total; base_done = done_total;
        repeat (4) step();
        push_frame(rec_d);
        drive0(rec_d, 1'b1);
        step();
        drive0(rec_junk, 1'b0);
        repeat (5) step();
        check("busy_holds_dv", dv_total - base_dv, 32'd0);
        check("busy_not_ready", {31'd0, ifc0.tx_ready}, 32'd0);
        force_busy = 1'b0;
        wait_frame_done("frame3_timeout");
        check("frame3_dv_count", dv_total - base_dv, NB);
        check("frame3_done_count", done_total - base_done, 32'd1);

        // Reset one cycle after byte 9's done, then a full frame from F0.
        push_frame(rec_e);
        base_ud = udone_total;
        drive0(rec_e, 1'b1);
        step();
        drive0(rec_e, 1'b0);
        n = 0;
        while ((udone_total - base_ud) < 10 && n < 300) begin step(); n++; end
        if (n >= 300) check("byte9_done_timeout", 32'd0, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q.delete();
        check_reset_values("midrst");
        push_frame(rec_aa);
        base_dv = dv_total; base_done = done_total;
        drive0(rec_aa, 1'b1);
        step();
        drive0(rec_junk, 1'b0);
        wait_frame_done("frame_aa_timeout");
        check("frame_aa_dv_count", dv_total - base_dv, NB);
        check("frame_aa_done_count", done_total - base_done, 32'd1);
        check("frame_aa_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
